// File: rtl/sequential_multiplier.sv
// sequential_multiplier: unsigned shift-and-add multiplier, one multiplier bit per clock, 2l-bit product.
// Optional MUL_EARLY_EXIT_EN: finish as soon as no set multiplier bits remain.
module sequential_multiplier #(
   parameter int l = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [l-1:0]   A,
   input  logic [l-1:0]   B,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*l-1:0] Product,
   output logic           Busy
);
   localparam int CW = (l > 1) ? $clog2(l) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [2*l-1:0] mcand, acc, acc_nxt;
   logic [l-1:0] mplier;
   logic [CW-1:0] cnt;
   logic last;
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
`ifdef MUL_EARLY_EXIT_EN
   // Nothing left to add once the shifted-out multiplier is empty.
   assign last = (cnt == CW'(l - 1)) || ((mplier >> 1) == '0);
`else
   assign last = cnt == CW'(l - 1);
`endif
   assign in_ready = state == IDLE;
   assign Busy = state == RUN;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= '0;
         acc <= '0;
         mplier <= '0;
         cnt <= '0;
         Product <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               mcand <= {{l{1'b0}}, A};
               mplier <= B;
               acc <= '0;
               cnt <= '0;
               state <= RUN;
            end
            RUN: begin
               acc <= acc_nxt;
               mcand <= mcand << 1;
               mplier <= mplier >> 1;
               cnt <= cnt + CW'(1);
               if (last) begin
                  Product <= acc_nxt;
                  out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sequential_multiplier.sv
// tb_sequential_multiplier: randomized self-checking bench for sequential_multiplier against an arithmetic model.
// Expected latency follows MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_sequential_multiplier;
   logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, Busy;
   logic [15:0] A, B;
   logic [31:0] Product;
   int nchk = 0, nfail = 0, cyc = 0, acc_cyc = 0;

   sequential_multiplier #(.l(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Product(Product), .Busy(Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
      int h = 0;
      for (int i = 0; i < 16; i++) if (b[i]) h = i;
      return h + 1;
`else
      return 16;
`endif
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
   task automatic op(input logic [15:0] a, input logic [15:0] b, input bit keep_valid);
      int n = 0, bn = 0;
      logic [31:0] exp_p;
      bit seen = 0;
      exp_p = {16'd0, a} * {16'd0, b};
      in_valid = 1'b1; A = a; B = b;
      nchk++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL in_ready_idle got=%b want=1", in_ready); end
      @(posedge clk); #1 acc_cyc = cyc;
      while (n < 40) begin
         @(negedge clk);
         in_valid = keep_valid; A = 16'($urandom); B = 16'($urandom);
         if (out_valid) begin seen = 1; break; end
         if (Busy && !in_ready) bn++;
         n++;
      end
      nchk++; if (!seen) begin nfail++; $display("FAIL timeout a=%h b=%h", a, b); end
      nchk++; if (n != exp_lat(b)) begin nfail++; $display("FAIL latency a=%h b=%h got=%0d want=%0d", a, b, n, exp_lat(b)); end
      nchk++; if (bn != exp_lat(b)) begin nfail++; $display("FAIL busy_cycles b=%h got=%0d want=%0d", b, bn, exp_lat(b)); end
      nchk++; if (Product !== exp_p) begin nfail++; $display("FAIL product a=%h b=%h got=%h want=%h", a, b, Product, exp_p); end
      nchk++; if (Busy !== 1'b0 || in_ready !== 1'b0) begin nfail++; $display("FAIL done_flags busy=%b in_ready=%b want 0/0", Busy, in_ready); end
   endtask

   task automatic test_reset;
      #2;
      nchk++; if ({in_ready, out_valid, Busy} !== 3'b100 || Product !== 32'd0) begin
         nfail++; $display("FAIL reset_state rdy/ov/busy=%b prod=%h want=100/0", {in_ready, out_valid, Busy}, Product); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nchk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nfail++; $display("FAIL after_reset rdy=%b ov=%b", in_ready, out_valid); end
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      op(16'h00FF, 16'h0101, 0); @(negedge clk);
      op(16'hFFFF, 16'hFFFF, 0); @(negedge clk);
      op(16'h0000, 16'hFFFF, 0); @(negedge clk);
   endtask

   task automatic test_early_exit_cases;
      out_ready = 1'b1;
      op(16'd1234, 16'h0000, 0); @(negedge clk);
      op(16'hABCD, 16'h0001, 0); @(negedge clk);
      op(16'h0001, 16'h8000, 0); @(negedge clk);
   endtask

   task automatic test_async_reset;
      int ov = 0, bz = 0;
      in_valid = 1'b1; A = 16'h1234; B = 16'hFFFF;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      nchk++; if ({in_ready, out_valid, Busy} !== 3'b100 || Product !== 32'd0) begin
         nfail++; $display("FAIL async_reset rdy/ov/busy=%b prod=%h want=100/0", {in_ready, out_valid, Busy}, Product); end
      @(negedge clk); rst_n = 1'b1;
      repeat (25) begin @(negedge clk); if (out_valid) ov++; if (Busy) bz++; end
      nchk++; if (ov != 0 || bz != 0) begin nfail++; $display("FAIL no_pulse_after_reset ov=%0d busy=%0d want=0", ov, bz); end
   endtask

   task automatic test_backpressure;
      int n = 0;
      out_ready = 1'b0;
      op(16'd3, 16'd7, 0);
      in_valid = 1'b1; A = 16'd5; B = 16'd5;
      repeat (5) begin
         @(negedge clk);
         nchk++; if (out_valid !== 1'b1 || Product !== 32'd21 || in_ready !== 1'b0) begin
            nfail++; $display("FAIL hold ov=%b prod=%0d rdy=%b want=1/21/0", out_valid, Product, in_ready); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Busy !== 1'b0) begin
         nfail++; $display("FAIL drain_no_accept ov=%b rdy=%b busy=%b want=0/1/0", out_valid, in_ready, Busy); end
      @(negedge clk);
      in_valid = 1'b0;
      nchk++; if (Busy !== 1'b1) begin nfail++; $display("FAIL accept_after_drain busy=%b want=1", Busy); end
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      nchk++; if (Product !== 32'd25 || out_valid !== 1'b1) begin nfail++; $display("FAIL bp_second prod=%0d ov=%b want=25/1", Product, out_valid); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [15:0] qa[3] = '{16'd2, 16'd100, 16'h8000};
      logic [15:0] qb[3] = '{16'd9, 16'd200, 16'd2};
      int prev = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op(qa[i], qb[i], 1);
         if (i > 0) begin
            nchk++; if (acc_cyc - prev != exp_lat(qb[i-1]) + 2) begin
               nfail++; $display("FAIL b2b_interval i=%0d got=%0d want=%0d", i, acc_cyc - prev, exp_lat(qb[i-1]) + 2); end
         end
         prev = acc_cyc;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random;
      logic [15:0] a, b;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom);
         b = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         op(a, b, i % 2);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
      test_reset;
      test_basic;
      test_async_reset;
      test_early_exit_cases;
      test_backpressure;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
Multi-cycle unsigned shift-and-add multiplier for the ALU. It is the inverse of the existing combinational restoring divider: it takes two l-bit operands and produces a full 2l-bit product.
- Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake.
- The block iterates one multiplier bit per clock, trading latency for a single l-bit-wide adder.

Parameters:
l, 16, operand width in bits; product width is 2l

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair A/B is valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  l  multiplicand, unsigned
B  input  l  multiplier, unsigned
out_valid  output  1  Product holds a completed result
out_ready  input  1  consumer accepts Product
Product  output  2l  result register, A*B
Busy  output  1  high in RUN state

Behaviour:
- Reset is asynchronous and active-low; one clock. Assertion of rst_n=0 immediately forces:
  - state=IDLE, out_valid=0, Busy=0, Product=0, internal registers=0;
  - in_ready=1, because in_ready is decoded from state==IDLE.
- States and transitions:
  - IDLE: in_ready=1. On an edge with in_valid&in_ready:
    - capture A zero-extended to 2l bits into the multiplicand register;
    - capture B into the multiplier register;
    - clear the accumulator; set the iteration counter to 0; go to RUN.
  - RUN: in_ready=0, Busy=1. Each edge:
    - if multiplier[0]=1, accumulator += multiplicand (2l-bit add, no overflow possible);
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - On the edge completing iteration l-1: load Product with the final accumulator value; go to DONE.
  - DONE: out_valid=1, in_ready=0, Busy=0.
    - On an edge with out_ready=1: go to IDLE, out_valid drops.
    - While out_ready=0: Product and out_valid are held stable indefinitely.
- Latency: out_valid rises exactly l rising edges after the accepting edge, for all operand values (default build).
- Throughput: one result per l+2 cycles minimum (accept edge, l RUN edges, drain edge).
- Product updates only on entry to DONE. It retains the last result in IDLE and RUN.
- in_valid while not in IDLE: ignored; operands are not latched; the upstream must hold them.
- In DONE, out_ready and in_valid both high on the same edge: the result drains; the new operands are NOT accepted on that edge. They are accepted at the earliest on the next edge (in IDLE).
- A, B are sampled only on the accepting edge; later changes have no effect on the in-flight operation.
- Reset mid-RUN or mid-DONE: the operation is discarded, with no out_valid pulse.
- Counter width: ceil(log2(l)) bits; it must not wrap before the DONE transition.

Optional Feature:
Macro MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the multiplier register value after this edge's shift is zero, load Product and go to DONE on that edge, regardless of counter.
  - If B==0 at acceptance, go from IDLE directly to DONE on the accepting edge's following edge, with Product=0 (latency 1).
  - Latency becomes (index of highest set bit of B)+1 edges, minimum 1.
- Undefined: fixed latency of l edges as above; no zero-detect logic is synthesized.

Test Plan:
1. Async reset: pulse rst_n low mid-RUN, between clock edges -> in_ready=1, out_valid=0, Busy=0, Product=0 immediately; no out_valid afterwards.
2. A=16'h00FF, B=16'h0101, out_ready=1 -> Busy high 16 cycles; out_valid exactly 16 edges after acceptance; Product=32'h0000FFFF.
3. A=16'hFFFF, B=16'hFFFF -> Product=32'hFFFE0001. Then A=16'h0000, B=16'hFFFF -> Product=0, still 16 edges latency (macro undefined).
4. Backpressure: A=3, B=7, out_ready=0 for 5 cycles after out_valid, in_valid held high with A=5, B=5 -> Product=21 stable, in_ready=0, new operands not taken. out_ready=1 for one edge -> IDLE. Next edge accepts 5*5 -> Product=25.
5. Back-to-back: in_valid held with stream (2,9),(100,200),(16'h8000,2), out_ready=1 -> Products 18, 20000, 32'h00010000 in order; in_ready asserts once per l+2 cycles.
6. MUL_EARLY_EXIT_EN defined:
   - B=0, A=1234 -> out_valid 1 edge after accept, Product=0.
   - B=16'h0001, A=16'hABCD -> 1 edge, Product=32'h0000ABCD.
   - B=16'h8000, A=1 -> 16 edges, Product=32'h00008000.
